fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the decode/execute datapath. Owns the program counter, issues single-cycle-latency reads to the synchronous instruction memory, tags each returned word with its PC, and presents `{pc, inst}` pairs to decode over a valid/ready handshake. Accepts a redirect (branch/jump target) from execute, flushing all wrong-path instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `XLEN`, 32, address/data width.
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: read enable to instruction memory this cycle.
- `imem_addr` out XLEN: byte address of read; bits [1:0] always 0.
- `imem_rdata` in 32: read data, valid the cycle after `imem_req`.
- `redirect_valid` in 1: replace PC and flush.
- `redirect_pc` in XLEN: new PC; bits [1:0] ignored (treated as 00).
- `out_valid` out 1: `out_inst`/`out_pc` hold a valid instruction.
- `out_ready` in 1: decode accepts this cycle.
- `out_inst` out 32: instruction word.
- `out_pc` out XLEN: address of `out_inst`.

## Operation
- State: `pc`, in-flight flag + in-flight PC, output buffer (depth D: 2 with `FETCH_SKID_EN`, else 1), occupancy count.
- Pop = `out_valid && out_ready`. Credit = occupancy + in-flight.
- Issue (`imem_req=1`, `imem_addr=pc`, `pc<=pc+4`) when no redirect and (credit < D, or credit == D and pop).
- Response: cycle after issue, `{inflight_pc, imem_rdata}` written to buffer tail unless killed.
- Redirect (highest priority): `pc<=redirect_pc & ~3`, buffer emptied, in-flight flag cleared (response next cycle discarded), `imem_req=0` that cycle. A pop in the same cycle is still a completed transfer for decode; buffer still flushed.
- `out_valid` = occupancy != 0; outputs driven from buffer head; stable while `out_valid && !out_ready`.
- PC arithmetic modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- Full buffer with no pop: no issue; no response lost (credit guarantees a slot).
- Reset (any time, async): `pc=RESET_PC`, occupancy 0, in-flight 0, `out_valid=0`, `imem_req=0`, `imem_addr=RESET_PC`, `out_inst=0`, `out_pc=0`. First issue in first cycle after `rst_n` deasserts.

## Timing
- Issue at cycle N -> buffer write end of N+1 -> `out_valid` at N+2 (fetch latency 2).
- Redirect at N -> issue from target at N+1 -> `out_valid` with target at N+3.
- Throughput with `FETCH_SKID_EN` and `out_ready` held 1: one instruction/cycle. Without: one per 2 cycles.
- No combinational path from `out_ready` or `imem_rdata` to `out_valid`/`out_inst`/`out_pc`. `imem_req`/`imem_addr` combinational from `redirect_valid`, `out_ready`, state.

## Configuration
- `FETCH_SKID_EN` defined: buffer depth 2, credit limit 2, full throughput.
- Undefined: depth 1, credit limit 1, half throughput, smaller area. Handshake, redirect and reset behaviour identical.

## Structure
- `fetch_pkg`: `XLEN`, `INST_BYTES`=4, `NOP_INST`=32'h0000_0013, buffer entry struct `{pc, inst}`.
- One sub-module: `fetch_buf` — parameterised depth 1/2 FIFO with async active-low reset, flush input, push/pop, count output.

## Test plan
- Reset release, memory word at addr k = k, `out_ready=1` -> `out_pc` 0,4,8,… with `out_inst` matching; first `out_valid` 2 cycles after reset; back-to-back with `FETCH_SKID_EN`, every other cycle without.
- Hold `out_ready=0` 5 cycles after first valid -> `out_valid` stays 1, `out_pc=0` stable, at most D+0 words buffered, no `imem_req` once credit full; release -> 4,8,… without gaps or duplicates.
- Redirect to 32'h100 while buffer full and a read in flight -> no pre-redirect PC ever appears after it; next `out_pc=0x100` exactly 3 cycles later.
- `redirect_pc=32'h203` -> `imem_addr=0x200`, `out_pc=0x200`.
- Redirect to 32'hFFFF_FFFC -> `out_pc` FFFF_FFFC then 0.
- Assert `rst_n=0` mid-stream with `out_valid=1` -> `out_valid`, `imem_req` fall immediately (asynchronously); after release fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and the {pc, inst} buffer entry for the fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0] inst;
  } entry_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 1- or 2-entry shifting FIFO of fetched {pc, inst} pairs; head is always entry 0.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);
  entry_t [DEPTH-1:0] mem;
  entry_t [DEPTH-1:0] shifted;
  logic [1:0] wr;
  assign shifted = mem >> $bits(entry_t);
  // a simultaneous pop moves the write slot down by one
  assign wr = count - 2'(pop);
  assign head = mem[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      count <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (push && wr == 2'(i)) mem[i] <= push_data;
        else if (pop) mem[i] <= shifted[i];
      count <= flush ? 2'd0 : count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing single-cycle imem reads and presenting {pc, inst} to decode.
// Defining FETCH_SKID_EN gives a 2-entry output buffer for one instruction per cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc
);
`ifdef FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] LIMIT = 2'(DEPTH);
  logic [XLEN-1:0] pc, inflight_pc;
  logic inflight, pop, push;
  logic [1:0] count, credit;
  entry_t head, resp;
  assign pop = out_valid && out_ready;
  assign credit = count + {1'b0, inflight};
  // credit counts the in-flight read, so every response is guaranteed a slot
  assign imem_req = rst_n && !redirect_valid && (credit < LIMIT || (credit == LIMIT && pop));
  assign imem_addr = pc;
  assign push = inflight && !redirect_valid;
  assign resp = '{pc: inflight_pc, inst: imem_rdata};
  assign out_valid = count != 2'd0;
  assign out_pc = head.pc;
  assign out_inst = head.inst;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      pc <= redirect_valid ? (redirect_pc & ~XLEN'(3)) : imem_req ? pc + XLEN'(INST_BYTES) : pc;
      inflight <= imem_req;
      if (imem_req) inflight_pc <= pc;
    end
  end
  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(resp),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );
endmodule
